// File: rtl/alu_issue_stage_pkg.sv
// Shared RV32I decode constants and ALU control encoding for the ALU issue stage.
// Imported by the interface, the top level and the bench.
package alu_issue_stage_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLL = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SR  = 3'b110,
    ALU_XOR = 3'b111
  } alu_ctrl_e;

  // Register/immediate arithmetic share one funct3 map; only the SUB select differs.
  function automatic alu_ctrl_e alu_op_map(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  return sub ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLT;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SR;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// ALU-side bus of the issue stage: valid/ready plus the operand and control fields
// consumed 1:1 by the combinational ALU.
interface alu_issue_stage_if
  import alu_issue_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  alu_ctrl_e        alu_ctrl;
  logic [2:0]       funct3;
  logic             funct7b5;
  logic [RD_W-1:0]  rd_out;
  logic             illegal;

  modport master (
    output out_valid, a, b, alu_ctrl, funct3, funct7b5, rd_out, illegal,
    input  out_ready
  );

  modport slave (
    input  out_valid, a, b, alu_ctrl, funct3, funct7b5, rd_out, illegal,
    output out_ready
  );
endinterface

// File: rtl/alu_issue_stage_skid.sv
// Generic 2-entry valid/ready buffer: a main output register plus one skid entry.
// in_ready comes straight from a flop, so there is no combinational out_ready->in_ready path.
module alu_issue_stage_skid #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);
  logic              main_valid_reg;
  logic              skid_valid_reg;
  logic [DATA_W-1:0] main_data_reg;
  logic [DATA_W-1:0] skid_data_reg;
  logic              accept;
  logic              main_free;

  assign accept    = in_valid && !skid_valid_reg && !flush;
  assign main_free = !main_valid_reg || out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      main_data_reg  <= '0;
      skid_data_reg  <= '0;
    end else if (flush) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (main_free) begin
      // Skid entry is older than anything arriving now, so it drains first.
      if (skid_valid_reg) begin
        main_data_reg  <= skid_data_reg;
        main_valid_reg <= 1'b1;
        skid_valid_reg <= 1'b0;
      end else if (accept) begin
        main_data_reg  <= in_data;
        main_valid_reg <= 1'b1;
      end else begin
        main_valid_reg <= 1'b0;
      end
    end else if (accept) begin
      skid_data_reg  <= in_data;
      skid_valid_reg <= 1'b1;
    end
  end

  assign in_ready  = !skid_valid_reg;
  assign out_valid = main_valid_reg;
  assign out_data  = main_data_reg;

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes RV32I fields into ALU control/operands and registers the
// result through a 2-entry skid buffer feeding the ALU bus.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3_in,
  input  logic             funct7b5_in,
  input  logic [WIDTH-1:0] rs1_val,
  input  logic [WIDTH-1:0] rs2_val,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] pc,
  input  logic [RD_W-1:0]  rd_in,
  alu_issue_stage_if.master alu_bus
);
  localparam int OFS_CTRL = 2 * WIDTH;
  localparam int OFS_F3   = OFS_CTRL + 3;
  localparam int OFS_F7   = OFS_F3 + 3;
  localparam int OFS_RD   = OFS_F7 + 1;
  localparam int OFS_ILL  = OFS_RD + RD_W;
  localparam int DATA_W   = OFS_ILL + 1;

  logic [WIDTH-1:0]  dec_a;
  logic [WIDTH-1:0]  dec_b;
  alu_ctrl_e         dec_ctrl;
  logic [2:0]        dec_f3;
  logic              dec_f7;
  logic              dec_ill;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] out_data;

  always_comb begin
    dec_a    = '0;
    dec_b    = '0;
    dec_ctrl = ALU_ADD;
    dec_f3   = 3'b000;
    dec_f7   = 1'b0;
    dec_ill  = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_a    = rs1_val;
        dec_b    = rs2_val;
        dec_ctrl = alu_op_map(funct3_in, funct7b5_in);
        dec_f3   = funct3_in;
        dec_f7   = (funct3_in == 3'b000 || funct3_in == 3'b101) ? funct7b5_in : 1'b0;
      end
      OPC_OPIMM: begin
        dec_a    = rs1_val;
        dec_b    = imm;
        dec_ctrl = alu_op_map(funct3_in, 1'b0);
        dec_f3   = funct3_in;
        dec_f7   = (funct3_in == 3'b101) ? funct7b5_in : 1'b0;
      end
      OPC_LOAD, OPC_STORE: begin
        dec_a = rs1_val;
        dec_b = imm;
      end
      OPC_LUI:   dec_b = imm;
      OPC_AUIPC: begin
        dec_a = pc;
        dec_b = imm;
      end
      OPC_JAL, OPC_JALR: begin
        // Link value pc+4; wrap-around is left to the ALU adder.
        dec_a = pc;
        dec_b = WIDTH'(4);
      end
      OPC_BRANCH: begin
        dec_a = rs1_val;
        dec_b = rs2_val;
        case (funct3_in[2:1])
          2'b10: begin
            dec_ctrl = ALU_SLT;
            dec_f3   = F3_SLT;
          end
          2'b11: begin
            dec_ctrl = ALU_SLT;
            dec_f3   = F3_SLTU;
          end
          default: begin
            dec_ctrl = ALU_SUB;
            dec_f3   = funct3_in;
          end
        endcase
      end
      // Unknown opcodes still issue so the trap is raised downstream in order.
      default: dec_ill = 1'b1;
    endcase
  end

  assign in_data = {dec_ill, rd_in, dec_f7, dec_f3, dec_ctrl, dec_b, dec_a};

  alu_issue_stage_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (alu_bus.out_valid),
    .out_ready (alu_bus.out_ready),
    .out_data  (out_data)
  );

  assign alu_bus.a        = out_data[WIDTH-1:0];
  assign alu_bus.b        = out_data[OFS_CTRL-1:WIDTH];
  assign alu_bus.alu_ctrl = alu_ctrl_e'(out_data[OFS_F3-1:OFS_CTRL]);
  assign alu_bus.funct3   = out_data[OFS_F7-1:OFS_F3];
  assign alu_bus.funct7b5 = out_data[OFS_F7];
  assign alu_bus.rd_out   = out_data[OFS_ILL-1:OFS_RD];
  assign alu_bus.illegal  = out_data[OFS_ILL];

endmodule
